// File: rtl/rtc_bus_sequencer.sv
// RTC bus sequencer: drives one address phase, a short gap and one data phase
// into the downstream signal generator. It captures read data during LL windows.
module rtc_bus_sequencer #(
    parameter int unsigned PHASE_LEN = 32,
    parameter int unsigned GAP       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] bus_in,
    input  logic       LL,
    output logic       EN_signals,
    output logic       read,
    output logic       dato,
    output logic [7:0] bus_out,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StAddr = 3'd1;
    localparam logic [2:0] StGap  = 3'd2;
    localparam logic [2:0] StData = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam logic [5:0] PhaseLast = 6'(PHASE_LEN - 1);
    localparam logic [5:0] GapLast   = 6'(GAP - 1);

    logic [2:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       en_d, read_d, dato_d, busy_d, done_d;
    logic [7:0] bus_out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 6'd1;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StAddr;
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            StAddr: begin
                if (cnt_q == PhaseLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (cnt_q == PhaseLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output is a plain register
    // that only moves on phase boundaries.
    always_comb begin
        en_d      = 1'b0;
        read_d    = 1'b0;
        dato_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        bus_out_d = 8'h00;
        case (state_d)
            StAddr: begin
                en_d      = 1'b1;
                busy_d    = 1'b1;
                bus_out_d = addr_d;
            end
            StGap: begin
                busy_d    = 1'b1;
                bus_out_d = addr_d;
            end
            StData: begin
                en_d      = 1'b1;
                read_d    = rw_d;
                dato_d    = 1'b1;
                busy_d    = 1'b1;
                bus_out_d = rw_d ? 8'h00 : wdata_d;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            EN_signals <= 1'b0;
            read       <= 1'b0;
            dato       <= 1'b0;
            bus_out    <= 8'h00;
            rdata      <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            EN_signals <= en_d;
            read       <= read_d;
            dato       <= dato_d;
            bus_out    <= bus_out_d;
            busy       <= busy_d;
            done       <= done_d;
            if (state_q == StData && rw_q && LL) begin
                rdata <= bus_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: a default instance and a PHASE_LEN=4/GAP=1 instance share
// stimulus, and both are checked every cycle against an offset-based transaction model.
module tb_rtc_bus_sequencer;

    logic       clk;
    logic       reset, start, rw, ll;
    logic [7:0] addr, wdata, bus_in;

    logic       en0, rd0, dato0, busy0, done0;
    logic [7:0] bo0, rdata0;
    logic       en1, rd1, dato1, busy1, done1;
    logic [7:0] bo1, rdata1;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_bus_sequencer #(.PHASE_LEN(32), .GAP(2)) dut0 (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .bus_in(bus_in), .LL(ll), .EN_signals(en0), .read(rd0), .dato(dato0),
        .bus_out(bo0), .rdata(rdata0), .busy(busy0), .done(done0)
    );

    rtc_bus_sequencer #(.PHASE_LEN(4), .GAP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .bus_in(bus_in), .LL(ll), .EN_signals(en1), .read(rd1), .dato(dato1),
        .bus_out(bo1), .rdata(rdata1), .busy(busy1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: off = cycles since start acceptance (0 = idle), done at off == 2*pl+g+1.
    typedef struct {
        int         off;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } model_t;

    model_t m0, m1;

    function automatic model_t mstep(model_t m, int pl, int g, logic rst, logic st,
                                     logic rw_i, logic [7:0] a, logic [7:0] w,
                                     logic [7:0] bi, logic l);
        model_t r = m;
        int tot = 2 * pl + g + 1;
        if (rst) begin
            r.off = 0; r.rw = 1'b0; r.addr = 8'h00; r.wdata = 8'h00; r.rdata = 8'h00;
        end else if (m.off == 0) begin
            if (st) begin
                r.off = 1; r.rw = rw_i; r.addr = a; r.wdata = w;
            end
        end else begin
            if (m.rw && l && m.off > pl + g && m.off <= 2 * pl + g) r.rdata = bi;
            r.off = (m.off == tot) ? 0 : m.off + 1;
        end
        return r;
    endfunction

    function automatic logic [20:0] mout(model_t m, int pl, int g);
        int   tot      = 2 * pl + g + 1;
        logic in_addr  = (m.off >= 1 && m.off <= pl);
        logic in_data  = (m.off > pl + g && m.off <= 2 * pl + g);
        logic addr_gap = (m.off >= 1 && m.off <= pl + g);
        logic [7:0] bo;
        if (addr_gap)     bo = m.addr;
        else if (in_data) bo = m.rw ? 8'h00 : m.wdata;
        else              bo = 8'h00;
        return {in_addr | in_data, in_data & m.rw, in_data, bo, m.rdata,
                (m.off >= 1 && m.off < tot), (m.off == tot)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        m0 = mstep(m0, 32, 2, reset, start, rw, addr, wdata, bus_in, ll);
        m1 = mstep(m1, 4, 1, reset, start, rw, addr, wdata, bus_in, ll);
        @(posedge clk);
        #1;
        chk("dut0_cycle", 32'({en0, rd0, dato0, bo0, rdata0, busy0, done0}), 32'(mout(m0, 32, 2)));
        chk("dut1_cycle", 32'({en1, rd1, dato1, bo1, rdata1, busy1, done1}), 32'(mout(m1, 4, 1)));
    endtask

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] bus_in;
        int         ll_lo;
        int         ll_hi;
        logic [7:0] exp_rdata;
    } txn_t;

    txn_t tv[5];

    // Full default-size transaction; LL window given in data-phase counter units.
    task automatic run_txn(input txn_t t);
        int en_cnt = 0;
        int rd_cnt = 0;
        int done_k = 0;
        logic [7:0] rd_at_done = 8'hxx;
        rw = t.rw; addr = t.addr; wdata = t.wdata; start = 1'b1;
        tick();
        start = 1'b0;
        chk("addr_phase_entry", 32'({en0, dato0, bo0}), 32'({1'b1, 1'b0, t.addr}));
        for (int k = 1; k <= 67; k++) begin
            int dc = k - 35;
            ll     = (dc >= t.ll_lo && dc <= t.ll_hi);
            bus_in = ll ? t.bus_in : 8'($urandom);
            en_cnt += int'(en0);
            rd_cnt += int'(rd0);
            if (done0) begin
                done_k     = k;
                rd_at_done = rdata0;
            end
            tick();
        end
        ll = 1'b0;
        chk("en_high_cycles", 32'(en_cnt), 32'd64);
        chk("read_high_cycles", 32'(rd_cnt), t.rw ? 32'd32 : 32'd0);
        chk("done_latency", 32'(done_k), 32'd67);
        chk("rdata_at_done", 32'(rd_at_done), 32'(t.exp_rdata));
    endtask

    initial begin
        int done_cnt;
        int done_k;
        logic [12:0] en_seq;

        tv[0] = '{1'b0, 8'h21, 8'h5A, 8'hFF, 0, 31, 8'h00};
        tv[1] = '{1'b1, 8'h24, 8'h00, 8'h37, 5, 17, 8'h37};
        tv[2] = '{1'b0, 8'h33, 8'hC3, 8'h44, 2, 9, 8'h37};
        tv[3] = '{1'b1, 8'h7F, 8'h12, 8'hA5, 31, 31, 8'hA5};
        tv[4] = '{1'b1, 8'h10, 8'h66, 8'h99, 99, -1, 8'hA5};

        m0 = '{0, 1'b0, 8'h00, 8'h00, 8'h00};
        m1 = m0;
        reset = 1'b1; start = 1'b1; rw = 1'b1; addr = 8'hAA; wdata = 8'hBB;
        bus_in = 8'hCC; ll = 1'b1;
        tick();
        tick();
        chk("reset_outputs", 32'({en0, rd0, dato0, bo0, rdata0, busy0, done0}), 32'd0);
        reset = 1'b0; start = 1'b0; ll = 1'b0;
        tick();

        // Table transactions, back-to-back: each new start lands in the first idle cycle.
        for (int i = 0; i < 5; i++) run_txn(tv[i]);

        // Starts during ADDR and DONE must be ignored.
        rw = 1'b0; addr = 8'h42; wdata = 8'h99; start = 1'b1;
        tick();
        done_cnt = 0; done_k = 0;
        for (int k = 1; k <= 75; k++) begin
            start = (k == 10 || k == 67);
            if (start) begin
                rw = 1'b1; addr = 8'hEE; wdata = 8'h11;
            end
            if (done0) begin
                done_cnt++;
                done_k = k;
            end
            tick();
        end
        start = 1'b0;
        chk("ignored_start_done_count", 32'(done_cnt), 32'd1);
        chk("ignored_start_done_time", 32'(done_k), 32'd67);

        // Reset in the middle of the data phase aborts without done.
        rw = 1'b1; addr = 8'h24; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 40; k++) tick();
        chk("in_data_before_reset", 32'({en0, dato0}), 32'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_abort_outputs", 32'({en0, rd0, dato0, bo0, busy0, done0}), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            done_cnt += int'(done0);
            tick();
        end
        chk("no_done_after_abort", 32'(done_cnt), 32'd0);
        run_txn(tv[0]);

        // Short instance: phases 4/1/4, done at start+10.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        rw = 1'b0; addr = 8'h5C; wdata = 8'hE7; start = 1'b1;
        tick();
        start = 1'b0;
        en_seq = '0; done_k = 0;
        for (int k = 1; k <= 12; k++) begin
            en_seq[k] = en1;
            if (done1 && done_k == 0) done_k = k;
            tick();
        end
        chk("short_done_latency", 32'(done_k), 32'd10);
        chk("short_en_pattern", 32'(en_seq), 32'h03DE);

        // Random traffic against the model, with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            reset  = ($urandom_range(0, 399) == 0);
            start  = ($urandom_range(0, 7) == 0);
            rw     = 1'($urandom);
            addr   = 8'($urandom);
            wdata  = 8'($urandom);
            bus_in = 8'($urandom);
            ll     = 1'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- PHASE_LEN, 32, cycles EN_signals stays high per bus phase.
- GAP, 2, cycles EN_signals stays low between the address and data phases (min 1).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- start, in, 1, transaction request; sampled only in IDLE.
- rw, in, 1, 1 = read, 0 = write.
- addr, in, 8, RTC register address.
- wdata, in, 8, write data.
- bus_in, in, 8, sampled AD bus value during reads.
- LL, in, 1, read-latch window from the downstream signal generator.
- EN_signals, out, 1, enables the downstream signal generator for one phase.
- read, out, 1, phase direction to the generator.
- dato, out, 1, 0 = address phase, 1 = data phase.
- bus_out, out, 8, value the generator's SS strobe drives onto AD.
- rdata, out, 8, last read result.
- busy, out, 1, high from start acceptance until the done cycle, exclusive.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, ADDR, GAP, DATA, DONE.
REQ-004 In IDLE, a cycle with start=1 SHALL do all of the following:
- latch rw, addr and wdata;
- clear the phase counter;
- enter ADDR on the next edge.
REQ-005 start SHALL be ignored in every state other than IDLE; the latched operands SHALL NOT change while busy=1.
REQ-006 A 6-bit phase counter SHALL count 0..PHASE_LEN-1 in ADDR and DATA, and 0..GAP-1 in GAP.
- It SHALL clear on every state change.
REQ-007 ADDR outputs SHALL be: EN_signals=1, read=0, dato=0, bus_out=latched addr.
- ADDR SHALL exit to GAP when the counter reaches PHASE_LEN-1.
REQ-008 GAP outputs SHALL be: EN_signals=0, read=0, dato=0, bus_out=latched addr.
- GAP SHALL exit to DATA when the counter reaches GAP-1.
- GAP guarantees the downstream cycle counter restarts from 0.
REQ-009 DATA outputs SHALL be: EN_signals=1, read=latched rw, dato=1.
- bus_out SHALL be latched wdata when rw=0, and 8'h00 when rw=1.
- DATA SHALL exit to DONE when the counter reaches PHASE_LEN-1.
REQ-010 In DATA with rw=1, rdata SHALL load bus_in on every cycle with LL=1.
- rdata thus holds the value sampled on the last LL-high cycle.
- rdata SHALL be unchanged in all other states, cycles and write transactions.
REQ-011 DONE SHALL last one cycle with done=1, busy=0, EN_signals=0, and SHALL then return to IDLE.
- A start asserted during DONE SHALL be ignored.
REQ-012 In IDLE: EN_signals=0, read=0, dato=0, bus_out=8'h00, busy=0, done=0.
REQ-013 All outputs SHALL be registered.
- EN_signals, read, dato and bus_out SHALL change only on phase boundaries, never within a phase.
REQ-014 Latency with defaults: start sampled at edge N gives EN_signals=1 for cycles N+1..N+32, EN_signals=0 for N+33..N+34, data phase N+35..N+66, done=1 at N+67.
- General form: done at N + 2*PHASE_LEN + GAP + 1.

Reset
REQ-015 Synchronous reset=1 SHALL force all of the following on the next edge:
- state=IDLE and counter=0;
- EN_signals=0, read=0, dato=0;
- bus_out=8'h00, rdata=8'h00;
- busy=0, done=0;
- latched operands=0.
REQ-016 Reset mid-transaction SHALL abort it with no done pulse.
- EN_signals SHALL be low the cycle after reset is sampled.
REQ-017 start asserted together with reset SHALL be ignored.

Verification
REQ-018 Write: start, rw=0, addr=8'h21, wdata=8'h5A.
- Expect EN_signals high 32 cycles with dato=0 and bus_out=8'h21.
- Then EN_signals low 2 cycles.
- Then 32 cycles with dato=1, read=0, bus_out=8'h5A.
- done at start+67; rdata unchanged.
REQ-019 Read: rw=1, addr=8'h24, with LL modelled high during data-phase counter 5..17 and bus_in=8'h37 there.
- Expect read=1 only in DATA.
- Expect rdata=8'h37 at done.
REQ-020 start pulsed again at start+10 and start+67 (during ADDR and DONE).
- Expect both ignored: no restart, operands unchanged, single done.
REQ-021 Reset asserted at start+40 (DATA).
- Expect IDLE outputs on the next cycle.
- Expect no done pulse; a new start then completes normally.
REQ-022 Back-to-back: second start in the first IDLE cycle after done.
- Expect ADDR on the next cycle with the new operands.
REQ-023 PHASE_LEN=4, GAP=1.
- Expect done at start+10 and phase lengths 4/1/4.
